pipe_ctrl_unit: RTL and testbench
=================================

# pipe_ctrl_unit

Pipelined control and hazard unit for the 5-stage datapath. Decodes the instruction in ID, carries its control bundle through ID/EX, EX/MEM and MEM/WB registers, detects load-use hazards, and generates the stall, bubble and EX-stage forwarding selects. It supersedes the purely combinational decoder: adds LW, register-address tracking, parametrised widths and a saturating stall counter.

## Interface
Parameters:
- OPW, 4, opcode width (≥4; opcodes below are zero-extended)
- REGW, 3, register-address width
- CNTW, 16, stall-counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_opcode  in  OPW  ID opcode
- id_rs, id_rt, id_rd  in  REGW each  ID register fields
- hold  in  1  external freeze (memory busy); all stage registers hold
- flush  in  1  kill the ID instruction (branch/exception)
- stall  out  1  load-use stall; upstream holds PC and IF/ID
- ex_alu_src  out  1  EX: 1 selects immediate
- ex_alu_op  out  2  EX: 00 ADD, 01 AND, 10 OR, 11 NOR
- ex_fwd_a, ex_fwd_b  out  2 each  EX operand select: 00 regfile, 01 MEM result, 10 WB result
- mem_mr, mem_mw  out  1 each  MEM read / write enables
- wb_mreg  out  1  WB: 1 selects memory data
- wb_en_rw  out  1  WB register write enable
- wb_waddr  out  REGW  WB destination register
- stall_cnt  out  CNTW  saturating count of stall cycles

## Operation
- Decode (invalid, unknown opcode, or flushed → all-zero bundle):
  - SW 0000: alu_src=1, op=ADD, mw=1; reads rs, rt; no write
  - NOR 0001 / AND 0111 / OR 1111: alu_src=0, op=NOR/AND/OR, en_rw=1, dest=rd; reads rs, rt
  - ADDI 0011: alu_src=1, op=ADD, en_rw=1, dest=rt; reads rs
  - LW 0010: alu_src=1, op=ADD, mr=1, mreg=1, en_rw=1, dest=rt; reads rs
- Register 0 is hardwired zero: a write with dest=0 has en_rw forced 0; reads of r0 never hazard or forward.
- Each stage register stores the bundle plus rs, rt, read-enable flags and dest.
- Load-use hazard: stall=1 when EX holds LW (mr=1) with dest≠0 equal to a register the ID instruction actually reads, id_valid=1, flush=0, hold=0.
- On stall: ID/EX loads a bubble (all zero); EX/MEM and MEM/WB advance normally.
- On flush (hold=0): ID/EX loads a bubble; stall forced 0.
- On hold: every stage register and stall_cnt keep their value; stall=0; flush is ignored and the requester keeps it asserted.
- Forwarding, per EX operand with read-enable set and source ≠0: MEM match with mem en_rw → 01; else WB match with wb en_rw → 10; else 00. MEM has priority. A MEM-stage LW never matches, because the stall prevents it.
- stall_cnt increments on each stall cycle and saturates at 2^CNTW−1.

## Timing
- Reset: all stage registers cleared to a bubble. All outputs are 0, including stall_cnt and wb_waddr.
- An instruction accepted in ID cycle N has its EX controls visible in cycle N+1, MEM in N+2, WB in N+3.
- stall and ex_fwd_* are combinational from registered state and ID inputs, with no added latency.
- A load-use hazard costs exactly one stall cycle. The next cycle selects ex_fwd=10 for the dependent instruction.
- Reset asserted mid-operation clears every stage immediately, regardless of clock.

## Structure
- ctrl_pkg holds opcode constants, ALU-op encodings, forwarding encodings, and the packed ctrl_bundle_t struct (alu_src, alu_op, mr, mw, mreg, en_rw, dest).
- Sub-module ctrl_decode is the combinational opcode→bundle decoder. The top level holds the stage registers, hazard detection, forwarding and the counter.

## Test plan
- Reset, then ADDI r1 followed by OR r3=r1|r2 → OR in EX has ex_fwd_a=01. Cycle after, the ADDI has wb_en_rw=1 and wb_waddr=1.
- LW r2 followed by AND r4=r2&r1 → stall=1 for one cycle and a bubble in EX. Then AND in EX has ex_fwd_a=10. stall_cnt=1.
- SW then LW with dest=r0 then NOR reading r0 → no stall, wb_en_rw=0 for the LW, ex_fwd=00.
- flush asserted with ADDI in ID → next cycle all EX controls 0. The ADDI never reaches WB.
- hold high for 3 cycles during LW/AND hazard → outputs and stall_cnt frozen, stall=0. After release, exactly one stall occurs.
- CNTW=2 with 5 hazards → stall_cnt saturates at 3. rst_n pulsed low mid-run → all outputs 0 asynchronously.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types for the pipelined control unit: opcodes, ALU/forwarding encodings and the
// per-stage control bundle carried from ID/EX through MEM/WB.
package ctrl_pkg;

    // Storage width for register fields inside stage registers; REGW must not exceed it.
    localparam int unsigned RegWMax = 8;

    localparam logic [3:0] OpSw   = 4'b0000;
    localparam logic [3:0] OpNor  = 4'b0001;
    localparam logic [3:0] OpLw   = 4'b0010;
    localparam logic [3:0] OpAddi = 4'b0011;
    localparam logic [3:0] OpAnd  = 4'b0111;
    localparam logic [3:0] OpOr   = 4'b1111;

    typedef enum logic [1:0] {
        AluAdd = 2'b00,
        AluAnd = 2'b01,
        AluOr  = 2'b10,
        AluNor = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        FwdReg = 2'b00,
        FwdMem = 2'b01,
        FwdWb  = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic               alu_src;
        alu_op_e            alu_op;
        logic               mr;
        logic               mw;
        logic               mreg;
        logic               en_rw;
        logic [RegWMax-1:0] dest;
    } ctrl_bundle_t;

    typedef struct packed {
        ctrl_bundle_t       ctrl;
        logic               re_rs;
        logic               re_rt;
        logic [RegWMax-1:0] rs;
        logic [RegWMax-1:0] rt;
    } stage_t;

    // MEM wins over WB; r0 and unread operands never forward.
    function automatic fwd_sel_e fwd_sel(input logic               re,
                                         input logic [RegWMax-1:0] src,
                                         input ctrl_bundle_t       mem,
                                         input ctrl_bundle_t       wb);
        fwd_sel_e sel;
        sel = FwdReg;
        if (re && (src != '0)) begin
            if (mem.en_rw && (mem.dest == src)) begin
                sel = FwdMem;
            end else if (wb.en_rw && (wb.dest == src)) begin
                sel = FwdWb;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational ID-stage decoder: opcode and register fields to a stage_t record.
// Invalid, killed or unknown instructions decode to an all-zero bubble.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int unsigned OPW  = 4,
    parameter int unsigned REGW = 3
) (
    input  logic            valid_i,
    input  logic            kill_i,
    input  logic [OPW-1:0]  opcode_i,
    input  logic [REGW-1:0] rs_i,
    input  logic [REGW-1:0] rt_i,
    input  logic [REGW-1:0] rd_i,
    output stage_t          stage_o
);

    logic [RegWMax-1:0] rs_w, rt_w, rd_w;

    always_comb begin
        rs_w = '0;
        rt_w = '0;
        rd_w = '0;
        rs_w[REGW-1:0] = rs_i;
        rt_w[REGW-1:0] = rt_i;
        rd_w[REGW-1:0] = rd_i;
    end

    always_comb begin
        stage_o = '0;
        if (valid_i && !kill_i) begin
            case (opcode_i)
                OPW'(OpSw): begin
                    stage_o.ctrl.alu_src = 1'b1;
                    stage_o.ctrl.alu_op  = AluAdd;
                    stage_o.ctrl.mw      = 1'b1;
                    stage_o.re_rs        = 1'b1;
                    stage_o.re_rt        = 1'b1;
                end
                OPW'(OpNor), OPW'(OpAnd), OPW'(OpOr): begin
                    if (opcode_i == OPW'(OpNor)) begin
                        stage_o.ctrl.alu_op = AluNor;
                    end else if (opcode_i == OPW'(OpAnd)) begin
                        stage_o.ctrl.alu_op = AluAnd;
                    end else begin
                        stage_o.ctrl.alu_op = AluOr;
                    end
                    stage_o.ctrl.en_rw = 1'b1;
                    stage_o.ctrl.dest  = rd_w;
                    stage_o.re_rs      = 1'b1;
                    stage_o.re_rt      = 1'b1;
                end
                OPW'(OpAddi): begin
                    stage_o.ctrl.alu_src = 1'b1;
                    stage_o.ctrl.alu_op  = AluAdd;
                    stage_o.ctrl.en_rw   = 1'b1;
                    stage_o.ctrl.dest    = rt_w;
                    stage_o.re_rs        = 1'b1;
                end
                OPW'(OpLw): begin
                    stage_o.ctrl.alu_src = 1'b1;
                    stage_o.ctrl.alu_op  = AluAdd;
                    stage_o.ctrl.mr      = 1'b1;
                    stage_o.ctrl.mreg    = 1'b1;
                    stage_o.ctrl.en_rw   = 1'b1;
                    stage_o.ctrl.dest    = rt_w;
                    stage_o.re_rs        = 1'b1;
                end
                default: ;
            endcase
            // r0 is hardwired zero, so a write to it is dropped here once and for all
            if (stage_o.ctrl.dest == '0) begin
                stage_o.ctrl.en_rw = 1'b0;
            end
            stage_o.rs = stage_o.re_rs ? rs_w : '0;
            stage_o.rt = stage_o.re_rt ? rt_w : '0;
        end
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control and hazard unit: ID/EX, EX/MEM, MEM/WB control registers, load-use
// stall, EX-stage forwarding selects and a saturating stall counter.
module pipe_ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int unsigned OPW  = 4,
    parameter int unsigned REGW = 3,
    parameter int unsigned CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [OPW-1:0]  id_opcode,
    input  logic [REGW-1:0] id_rs,
    input  logic [REGW-1:0] id_rt,
    input  logic [REGW-1:0] id_rd,
    input  logic            hold,
    input  logic            flush,
    output logic            stall,
    output logic            ex_alu_src,
    output logic [1:0]      ex_alu_op,
    output logic [1:0]      ex_fwd_a,
    output logic [1:0]      ex_fwd_b,
    output logic            mem_mr,
    output logic            mem_mw,
    output logic            wb_mreg,
    output logic            wb_en_rw,
    output logic [REGW-1:0] wb_waddr,
    output logic [CNTW-1:0] stall_cnt
);

    stage_t          id_stage;
    stage_t          idex_q, idex_d;
    stage_t          exmem_q, exmem_d;
    stage_t          memwb_q, memwb_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            load_use;

    ctrl_decode #(
        .OPW  (OPW),
        .REGW (REGW)
    ) u_decode (
        .valid_i  (id_valid),
        .kill_i   (flush),
        .opcode_i (id_opcode),
        .rs_i     (id_rs),
        .rt_i     (id_rt),
        .rd_i     (id_rd),
        .stage_o  (id_stage)
    );

    always_comb begin
        load_use = 1'b0;
        if (idex_q.ctrl.mr && (idex_q.ctrl.dest != '0) && id_valid && !flush && !hold) begin
            load_use = (id_stage.re_rs && (id_stage.rs == idex_q.ctrl.dest)) ||
                       (id_stage.re_rt && (id_stage.rt == idex_q.ctrl.dest));
        end
    end

    // A flushed instruction already decodes to a bubble, so only the stall needs muxing here.
    always_comb begin
        idex_d  = idex_q;
        exmem_d = exmem_q;
        memwb_d = memwb_q;
        cnt_d   = cnt_q;
        if (!hold) begin
            idex_d  = load_use ? '0 : id_stage;
            exmem_d = idex_q;
            memwb_d = exmem_q;
            if (load_use && (cnt_q != {CNTW{1'b1}})) begin
                cnt_d = cnt_q + CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
            cnt_q   <= '0;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        stall      = load_use;
        ex_alu_src = idex_q.ctrl.alu_src;
        ex_alu_op  = idex_q.ctrl.alu_op;
        ex_fwd_a   = fwd_sel(idex_q.re_rs, idex_q.rs, exmem_q.ctrl, memwb_q.ctrl);
        ex_fwd_b   = fwd_sel(idex_q.re_rt, idex_q.rt, exmem_q.ctrl, memwb_q.ctrl);
        mem_mr     = exmem_q.ctrl.mr;
        mem_mw     = exmem_q.ctrl.mw;
        wb_mreg    = memwb_q.ctrl.mreg;
        wb_en_rw   = memwb_q.ctrl.en_rw;
        wb_waddr   = memwb_q.ctrl.dest[REGW-1:0];
        stall_cnt  = cnt_q;
    end

    // MEM/WB carries the full record for uniformity; only part of it drives outputs.
    logic unused_memwb;
    assign unused_memwb = ^memwb_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: instruction-level pipeline model checked every cycle, plus
// directed scenarios with literal expectations. A CNTW=2 copy shares all stimulus.
module tb_pipe_ctrl_unit;

    localparam int unsigned OPW  = 4;
    localparam int unsigned REGW = 3;
    localparam int unsigned CNTW = 16;

    localparam logic [3:0] SW   = 4'b0000;
    localparam logic [3:0] NOR  = 4'b0001;
    localparam logic [3:0] LW   = 4'b0010;
    localparam logic [3:0] ADDI = 4'b0011;
    localparam logic [3:0] AND  = 4'b0111;
    localparam logic [3:0] OR   = 4'b1111;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            id_valid = 1'b0;
    logic [OPW-1:0]  id_opcode = '0;
    logic [REGW-1:0] id_rs = '0, id_rt = '0, id_rd = '0;
    logic            hold = 1'b0, flush = 1'b0;

    logic            stall, ex_alu_src, mem_mr, mem_mw, wb_mreg, wb_en_rw;
    logic [1:0]      ex_alu_op, ex_fwd_a, ex_fwd_b;
    logic [REGW-1:0] wb_waddr;
    logic [CNTW-1:0] stall_cnt;

    logic            stall2, ex_alu_src2, mem_mr2, mem_mw2, wb_mreg2, wb_en_rw2;
    logic [1:0]      ex_alu_op2, ex_fwd_a2, ex_fwd_b2;
    logic [REGW-1:0] wb_waddr2;
    logic [1:0]      stall_cnt2;

    pipe_ctrl_unit #(.OPW(OPW), .REGW(REGW), .CNTW(CNTW)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .hold(hold), .flush(flush),
        .stall(stall), .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
        .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b), .mem_mr(mem_mr), .mem_mw(mem_mw),
        .wb_mreg(wb_mreg), .wb_en_rw(wb_en_rw), .wb_waddr(wb_waddr), .stall_cnt(stall_cnt)
    );

    pipe_ctrl_unit #(.OPW(OPW), .REGW(REGW), .CNTW(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .hold(hold), .flush(flush),
        .stall(stall2), .ex_alu_src(ex_alu_src2), .ex_alu_op(ex_alu_op2),
        .ex_fwd_a(ex_fwd_a2), .ex_fwd_b(ex_fwd_b2), .mem_mr(mem_mr2), .mem_mw(mem_mw2),
        .wb_mreg(wb_mreg2), .wb_en_rw(wb_en_rw2), .wb_waddr(wb_waddr2),
        .stall_cnt(stall_cnt2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- instruction-level model ----------------
    typedef struct {
        bit re_rs, re_rt;
        int rs, rt, dest, op;
        bit alu_src, mr, mw, mreg, en_rw;
    } ins_t;

    function automatic ins_t bubble();
        ins_t b;
        b = '{default: 0};
        return b;
    endfunction

    function automatic ins_t model_decode(bit v, bit fl, int op, int rs, int rt, int rd);
        ins_t r;
        r = bubble();
        if (!v || fl) return r;
        case (op)
            0: begin r.alu_src = 1; r.mw = 1; r.re_rs = 1; r.re_rt = 1; end
            1, 7, 15: begin
                r.op = (op == 1) ? 3 : (op == 7) ? 1 : 2;
                r.en_rw = 1; r.dest = rd; r.re_rs = 1; r.re_rt = 1;
            end
            3: begin r.alu_src = 1; r.en_rw = 1; r.dest = rt; r.re_rs = 1; end
            2: begin r.alu_src = 1; r.mr = 1; r.mreg = 1; r.en_rw = 1; r.dest = rt; r.re_rs = 1; end
            default: return r;
        endcase
        r.rs = rs;
        r.rt = rt;
        if (r.dest == 0) r.en_rw = 0;
        return r;
    endfunction

    ins_t m_ex = '{default: 0};
    ins_t m_mem = '{default: 0};
    ins_t m_wb = '{default: 0};
    int   m_cnt = 0;
    int   m_cnt2 = 0;

    function automatic ins_t cur_id();
        return model_decode(id_valid, flush, int'(id_opcode), int'(id_rs), int'(id_rt),
                            int'(id_rd));
    endfunction

    function automatic bit model_stall();
        ins_t d;
        d = cur_id();
        if (!m_ex.mr || m_ex.dest == 0 || !id_valid || flush || hold) return 0;
        return (d.re_rs && d.rs == m_ex.dest) || (d.re_rt && d.rt == m_ex.dest);
    endfunction

    function automatic int model_fwd(bit re, int src);
        if (!re || src == 0) return 0;
        if (m_mem.en_rw && m_mem.dest == src) return 1;
        if (m_wb.en_rw && m_wb.dest == src) return 2;
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ex   <= bubble();
            m_mem  <= bubble();
            m_wb   <= bubble();
            m_cnt  <= 0;
            m_cnt2 <= 0;
        end else if (!hold) begin
            m_wb  <= m_mem;
            m_mem <= m_ex;
            m_ex  <= model_stall() ? bubble() : cur_id();
            if (model_stall()) begin
                m_cnt  <= (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
                m_cnt2 <= (m_cnt2 < 3) ? m_cnt2 + 1 : m_cnt2;
            end
        end
    end

    function automatic logic [31:0] exp_pack();
        return 32'({model_stall(), m_ex.alu_src, 2'(m_ex.op),
                    2'(model_fwd(m_ex.re_rs, m_ex.rs)), 2'(model_fwd(m_ex.re_rt, m_ex.rt)),
                    m_mem.mr, m_mem.mw, m_wb.mreg, m_wb.en_rw, 3'(m_wb.dest)});
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            check("stall", 32'(stall), 32'(model_stall()));
            check("ex_ctrl", 32'({ex_alu_src, ex_alu_op}), 32'({m_ex.alu_src, 2'(m_ex.op)}));
            check("ex_fwd_a", 32'(ex_fwd_a), 32'(model_fwd(m_ex.re_rs, m_ex.rs)));
            check("ex_fwd_b", 32'(ex_fwd_b), 32'(model_fwd(m_ex.re_rt, m_ex.rt)));
            check("mem_ctrl", 32'({mem_mr, mem_mw}), 32'({m_mem.mr, m_mem.mw}));
            check("wb_ctrl", 32'({wb_mreg, wb_en_rw, wb_waddr}),
                  32'({m_wb.mreg, m_wb.en_rw, 3'(m_wb.dest)}));
            check("stall_cnt", 32'(stall_cnt), m_cnt);
            check("cntw2_outputs", 32'({stall2, ex_alu_src2, ex_alu_op2, ex_fwd_a2, ex_fwd_b2,
                                        mem_mr2, mem_mw2, wb_mreg2, wb_en_rw2, wb_waddr2}),
                  exp_pack());
            check("cntw2_stall_cnt", 32'(stall_cnt2), m_cnt2);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input logic v, input logic [3:0] op, input logic [2:0] rs,
                         input logic [2:0] rt, input logic [2:0] rd,
                         input logic h = 1'b0, input logic f = 1'b0);
        @(posedge clk);
        #1;
        id_valid  = v;
        id_opcode = op;
        id_rs     = rs;
        id_rt     = rt;
        id_rd     = rd;
        hold      = h;
        flush     = f;
        @(negedge clk);
        #1;
    endtask

    task automatic nop();
        drive(1'b0, SW, 3'd0, 3'd0, 3'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outs"}, 32'({stall, ex_alu_src, ex_alu_op, ex_fwd_a, ex_fwd_b, mem_mr,
                                   mem_mw, wb_mreg, wb_en_rw, wb_waddr}), 32'd0);
        check({tag, "_cnt"}, 32'(stall_cnt), 32'd0);
        check({tag, "_outs2"}, 32'({stall2, ex_alu_src2, ex_alu_op2, ex_fwd_a2, ex_fwd_b2,
                                    mem_mr2, mem_mw2, wb_mreg2, wb_en_rw2, wb_waddr2,
                                    stall_cnt2}), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        #1 check_all_zero("post_reset");

        // ADDI r1 then OR r3 = r1|r2: MEM forward, then WB write of r1
        drive(1'b1, ADDI, 3'd0, 3'd1, 3'd0);
        drive(1'b1, OR, 3'd1, 3'd2, 3'd3);
        check("t1_no_stall", 32'(stall), 32'd0);
        nop();
        check("t1_fwd_a", 32'(ex_fwd_a), 32'd1);
        check("t1_alu_op", 32'(ex_alu_op), 32'd2);
        nop();
        check("t1_wb", 32'({wb_en_rw, wb_waddr}), 32'({1'b1, 3'd1}));

        // LW r2 then AND r4 = r2&r1: one stall, bubble, WB forward
        drive(1'b1, LW, 3'd0, 3'd2, 3'd0);
        drive(1'b1, AND, 3'd2, 3'd1, 3'd4);
        check("t2_stall", 32'(stall), 32'd1);
        drive(1'b1, AND, 3'd2, 3'd1, 3'd4);
        check("t2_stall_once", 32'(stall), 32'd0);
        check("t2_bubble", 32'({ex_alu_src, ex_alu_op, mem_mr}), 32'({1'b0, 2'd0, 1'b1}));
        nop();
        check("t2_fwd_a", 32'(ex_fwd_a), 32'd2);
        check("t2_cnt", 32'(stall_cnt), 32'd1);

        // SW, LW into r0, NOR reading r0: no hazard, no forward, no write
        drive(1'b1, SW, 3'd1, 3'd2, 3'd0);
        drive(1'b1, LW, 3'd1, 3'd0, 3'd0);
        drive(1'b1, NOR, 3'd0, 3'd0, 3'd5);
        check("t3_no_stall", 32'(stall), 32'd0);
        nop();
        check("t3_fwd", 32'({ex_fwd_a, ex_fwd_b}), 32'd0);
        check("t3_nor_op", 32'(ex_alu_op), 32'd3);
        nop();
        check("t3_lw_r0_wb", 32'({wb_mreg, wb_en_rw}), 32'({1'b1, 1'b0}));

        // Flushed ADDI r6 becomes a bubble and never writes back
        drive(1'b1, ADDI, 3'd0, 3'd6, 3'd0, 1'b0, 1'b1);
        nop();
        check("t4_ex_bubble", 32'({ex_alu_src, ex_alu_op}), 32'd0);
        nop();
        nop();
        check("t4_no_wb", 32'({wb_en_rw, wb_waddr}), 32'd0);

        // Hold during a load-use hazard freezes everything; one stall after release
        drive(1'b1, LW, 3'd0, 3'd2, 3'd0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, AND, 3'd2, 3'd1, 3'd4, 1'b1);
            check("t5_hold_stall", 32'(stall), 32'd0);
            check("t5_hold_ex", 32'(ex_alu_src), 32'd1);
            check("t5_hold_cnt", 32'(stall_cnt), 32'd1);
        end
        drive(1'b1, AND, 3'd2, 3'd1, 3'd4);
        check("t5_release_stall", 32'(stall), 32'd1);
        drive(1'b1, AND, 3'd2, 3'd1, 3'd4);
        check("t5_single_stall", 32'(stall), 32'd0);
        nop();
        check("t5_fwd_a", 32'(ex_fwd_a), 32'd2);
        check("t5_cnt", 32'(stall_cnt), 32'd2);

        // WB on one operand, MEM on the other; then MEM priority over WB
        drive(1'b1, ADDI, 3'd0, 3'd1, 3'd0);
        drive(1'b1, ADDI, 3'd0, 3'd2, 3'd0);
        drive(1'b1, OR, 3'd1, 3'd2, 3'd3);
        nop();
        check("t6_fwd_mix", 32'({ex_fwd_a, ex_fwd_b}), 32'({2'd2, 2'd1}));
        drive(1'b1, ADDI, 3'd0, 3'd1, 3'd0);
        drive(1'b1, ADDI, 3'd0, 3'd1, 3'd0);
        drive(1'b1, AND, 3'd1, 3'd1, 3'd4);
        nop();
        check("t6_mem_priority", 32'({ex_fwd_a, ex_fwd_b}), 32'({2'd1, 2'd1}));

        // Invalid ID never stalls; unknown opcode is a bubble
        drive(1'b1, LW, 3'd0, 3'd3, 3'd0);
        drive(1'b0, AND, 3'd3, 3'd3, 3'd5);
        check("t7_invalid_no_stall", 32'(stall), 32'd0);
        drive(1'b1, 4'b0101, 3'd1, 3'd2, 3'd3);
        nop();
        check("t7_unknown_bubble", 32'({ex_alu_src, ex_alu_op}), 32'd0);

        // Five more hazards: wide counter reaches 7, CNTW=2 copy saturates at 3
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, LW, 3'd0, 3'd3, 3'd0);
            drive(1'b1, AND, 3'd3, 3'd3, 3'd5);
            drive(1'b1, AND, 3'd3, 3'd3, 3'd5);
        end
        nop();
        check("t8_cnt", 32'(stall_cnt), 32'd7);
        check("t8_cnt2_sat", 32'(stall_cnt2), 32'd3);

        // Asynchronous reset mid-run, away from any clock edge
        drive(1'b1, ADDI, 3'd0, 3'd1, 3'd0);
        drive(1'b1, OR, 3'd1, 3'd2, 3'd3);
        #1 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        nop();
        nop();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
